instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer-side counterpart of the instruction memory read port.
- Receives a program image as a byte stream: length header, little-endian instruction words, XOR checksum.
- Assembles 32-bit words and drives the instruction memory write port (byte addresses, word-aligned).
- Holds the CPU stalled while loading, then releases it or flags an error.

Parameters:
DEPTH, 1024, instruction memory capacity in 32-bit words; largest legal word count.
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load session when idle.
rx_data  input  8  incoming image byte.
rx_valid  input  1  rx_data valid this cycle.
rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
mem_addr  output  32  byte address of the write; BASE_ADDR + 4*index.
mem_wdata  output  32  assembled instruction word.
cpu_hold  output  1  stalls/resets the CPU while a session is active or failed.
busy  output  1  session in progress.
done  output  1  last session completed with a correct checksum; sticky.
error  output  1  last session failed; sticky.
words_loaded  output  16  count of words written in the current/last session.

Behaviour:
- Reset: state IDLE. rx_ready, mem_we, cpu_hold, busy, done, error = 0. mem_addr = BASE_ADDR. mem_wdata = 0. words_loaded = 0. Internal length, byte index and checksum are cleared.
- Reset mid-session: abort immediately. No further mem_we. Any partial word is discarded. Words already written stay in memory.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE / DONE / ERR, on start=1:
  - go to LEN_LO; set busy=1, cpu_hold=1; clear done, error, words_loaded and checksum.
  - mem_addr = BASE_ADDR.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- rx_ready = 1 exactly in LEN_LO, LEN_HI, DATA and CSUM. Up to one byte is accepted per cycle; rx_valid gaps are allowed.
- LEN_LO: accepted byte becomes N[7:0]; go to LEN_HI.
- LEN_HI: accepted byte becomes N[15:8], then:
  - N > DEPTH: go to ERR.
  - N == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA:
  - Bytes fill the word little-endian: 1st byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
  - Each data byte is XORed into an 8-bit running checksum. Length bytes are excluded.
  - In the cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = BASE_ADDR + 4*words_loaded (value before increment).
  - words_loaded increments in that same cycle.
  - rx_ready stays 1 during the write pulse, so back-to-back bytes are never stalled.
  - After word N is written, go to CSUM.
- CSUM: accepted byte compared to the running checksum.
  - Equal: go to DONE.
  - Otherwise: go to ERR.
- DONE: busy=0, cpu_hold=0, done=1. Held until the next start or RST.
- ERR: busy=0, cpu_hold stays 1, error=1. Held until the next start or RST.
- No memory writes occur outside DATA. mem_addr and mem_wdata hold their last values between pulses.
- Address arithmetic is 32-bit unsigned. With N ≤ DEPTH, the highest address is BASE_ADDR + 4*(DEPTH-1), so no wrap occurs.

Test Plan:
- Single-word load: start, then bytes 01 00 | 13 05 A0 00 | checksum B6 (13^05^A0^00) -> one mem_we pulse with addr 0x0, data 0x00A00513; done=1, cpu_hold=0, words_loaded=1.
- Three words with random 0–3-cycle rx_valid gaps -> 3 pulses at addrs 0x0, 0x4, 0x8 with correct little-endian data; no byte lost; done=1.
- Checksum mismatch: same image as the first scenario but checksum 00 -> word still written; error=1, cpu_hold stays 1, done=0.
- Zero or oversize length:
  - N=0 with checksum 00 -> no mem_we; done=1.
  - N=DEPTH+1 (01 04 with DEPTH=1024) -> ERR right after the 2nd byte; rx_ready=0; no mem_we.
- Start while busy: pulse start during DATA -> ignored; the session completes normally with the original N.
- RST after 6 data bytes of a 2-word load -> exactly 1 mem_we seen. All outputs return to reset values next cycle. A following start and full image reloads correctly from addr 0x0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program-image loader: it receives a length-prefixed byte stream, assembles little-endian
// 32-bit words and writes them into instruction memory while the CPU is held.
module instr_mem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state, state_nx;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  logic        accept;
  logic        start_session;
  logic [15:0] len_in;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_in    = {rx_data, len[7:0]};
  assign last_word = (16'(words_loaded + 16'd1) == len);

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked process.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    state_nx      = state;
    rx_ready      = 1'b0;
    busy          = 1'b0;
    cpu_hold      = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    start_session = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        done     = (state == DONE);
        error    = (state == ERR);
        cpu_hold = (state == ERR);
        if (start) begin
          start_session = 1'b1;
          state_nx      = LEN_LO;
        end
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (accept) state_nx = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (accept) begin
          if ({1'b0, len_in} > DEPTH_L) state_nx = ERR;
          else if (len_in == 16'd0)     state_nx = CSUM;
          else                          state_nx = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        // The last word's write pulse lands in the first CSUM cycle, so the checksum byte may follow back-to-back.
        if (accept && byte_idx == 2'd3 && last_word) state_nx = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (accept) state_nx = (rx_data == csum) ? DONE : ERR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_session) begin
        byte_idx     <= '0;
        csum         <= '0;
        mem_addr     <= BASE_ADDR;
        words_loaded <= '0;
      end
      if (accept) begin
        case (state)
          LEN_LO: len[7:0]  <= rx_data;
          LEN_HI: len[15:8] <= rx_data;
          DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_wdata    <= {rx_data, word_buf};
              mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
              words_loaded <= words_loaded + 16'd1;
            end else begin
              word_buf[8*byte_idx +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: image loads, checksum and length errors,
// ignored start, and reset mid-session.
module tb_instr_mem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [7:0]  img[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 CLK = ~CLK;

  instr_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always @(negedge CLK) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge CLK);
      rx_valid = 1'b0;
    end
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else @(posedge CLK);
  endtask

  task automatic send_img(input int max_gap);
    foreach (img[i]) send_byte(img[i], int'($urandom_range(0, max_gap)));
    @(negedge CLK);
    rx_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
    check({tag, "_addr"},     mem_addr,      32'h0);
    check({tag, "_wdata"},    mem_wdata,     32'h0);
    check({tag, "_words"},    32'(words_loaded), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_vals("rst");

    // Single-word load
    clear_writes();
    pulse_start();
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_hold_active", 32'(cpu_hold), 32'd1);
    img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    send_img(0);
    check("s1_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("s1_addr", wr_addr[0], 32'h0);
      check("s1_data", wr_data[0], 32'h00A00513);
    end
    check("s1_done", 32'(done), 32'd1);
    check("s1_hold", 32'(cpu_hold), 32'd0);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_words", 32'(words_loaded), 32'd1);

    // Three words with random rx_valid gaps; checksum 0x3D
    clear_writes();
    pulse_start();
    img = '{8'h03, 8'h00,
            8'h44, 8'h33, 8'h22, 8'h11,
            8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'h0D, 8'hF0, 8'hAD, 8'h0B,
            8'h3D};
    send_img(3);
    check("s2_nwr", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("s2_addr0", wr_addr[0], 32'h0);
      check("s2_data0", wr_data[0], 32'h11223344);
      check("s2_addr1", wr_addr[1], 32'h4);
      check("s2_data1", wr_data[1], 32'hDEADBEEF);
      check("s2_addr2", wr_addr[2], 32'h8);
      check("s2_data2", wr_data[2], 32'h0BADF00D);
    end
    check("s2_done", 32'(done), 32'd1);
    check("s2_words", 32'(words_loaded), 32'd3);

    // Checksum mismatch
    clear_writes();
    pulse_start();
    check("s3_done_cleared", 32'(done), 32'd0);
    img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
    send_img(0);
    check("s3_nwr", 32'(wr_addr.size()), 32'd1);
    check("s3_error", 32'(error), 32'd1);
    check("s3_hold", 32'(cpu_hold), 32'd1);
    check("s3_done", 32'(done), 32'd0);
    check("s3_busy", 32'(busy), 32'd0);

    // Zero length
    clear_writes();
    pulse_start();
    img = '{8'h00, 8'h00, 8'h00};
    send_img(0);
    check("s4_nwr", 32'(wr_addr.size()), 32'd0);
    check("s4_done", 32'(done), 32'd1);
    check("s4_error", 32'(error), 32'd0);
    check("s4_words", 32'(words_loaded), 32'd0);

    // Oversize length DEPTH+1
    clear_writes();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    @(negedge CLK);
    rx_valid = 1'b0;
    check("s5_error", 32'(error), 32'd1);
    check("s5_rx_ready", 32'(rx_ready), 32'd0);
    check("s5_hold", 32'(cpu_hold), 32'd1);
    check("s5_nwr", 32'(wr_addr.size()), 32'd0);

    // Start during DATA is ignored; checksum 0xB6 ^ 0x93 = 0x25
    clear_writes();
    pulse_start();
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};
    foreach (img[i]) send_byte(img[i], 0);
    @(negedge CLK);
    rx_valid = 1'b0;
    pulse_start();
    check("s6_busy_mid", 32'(busy), 32'd1);
    img = '{8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h25};
    send_img(0);
    check("s6_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("s6_data0", wr_data[0], 32'h00A00513);
      check("s6_addr1", wr_addr[1], 32'h4);
      check("s6_data1", wr_data[1], 32'h00000093);
    end
    check("s6_done", 32'(done), 32'd1);
    check("s6_words", 32'(words_loaded), 32'd2);

    // Reset after 6 data bytes of a 2-word load
    clear_writes();
    pulse_start();
    img = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (img[i]) send_byte(img[i], 0);
    @(negedge CLK);
    rx_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("s7");
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("s7_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("s7_addr", wr_addr[0], 32'h0);
      check("s7_data", wr_data[0], 32'h04030201);
    end
    clear_writes();
    pulse_start();
    img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    send_img(1);
    check("s7_reload_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("s7_reload_addr", wr_addr[0], 32'h0);
      check("s7_reload_data", wr_data[0], 32'h00A00513);
    end
    check("s7_reload_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
